// File: rtl/pb_onehot_sequencer_pkg.sv
// Shared types and constant helpers for the program-block sequencer.
package pb_onehot_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pb_bin2onehot.sv
// Binary index to one-hot decoder; indices at or beyond N decode to all-zero.
module pb_bin2onehot #(
  parameter int unsigned N = 12,
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_idx,
  output logic [N-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (i_idx == W'(k)) o_onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/pb_onehot_sequencer.sv
// Walks a configured chain of program blocks, driving a registered one-hot select bus
// that advances one iteration per step pulse.
module pb_onehot_sequencer
  import pb_onehot_sequencer_pkg::*;
#(
  parameter int unsigned MAX_NO_OF_PROGRAM_BLOCKS = 12,
  parameter int unsigned CNT_WIDTH                = 16,
  parameter int unsigned PB_IDX_WIDTH             = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_cfg_we,
  input  logic [PB_IDX_WIDTH-1:0]             i_cfg_addr,
  input  logic [CNT_WIDTH-1:0]                i_cfg_len,
  input  logic [PB_IDX_WIDTH-1:0]             i_cfg_next,
  input  logic                                i_cfg_last,
  input  logic                                i_start,
  input  logic                                i_step,
  input  logic                                i_abort,
  output logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0] o_s,
  output logic [PB_IDX_WIDTH-1:0]             o_pb_idx,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_err
);

  if (PB_IDX_WIDTH < clog2(MAX_NO_OF_PROGRAM_BLOCKS)) begin : g_bad_idx_width
    $error("PB_IDX_WIDTH too small for MAX_NO_OF_PROGRAM_BLOCKS");
  end

  // One extra bit so indices and the block count compare without truncation.
  localparam logic [PB_IDX_WIDTH:0] MaxPb = (PB_IDX_WIDTH + 1)'(MAX_NO_OF_PROGRAM_BLOCKS);

  logic [CNT_WIDTH-1:0]    r_len  [MAX_NO_OF_PROGRAM_BLOCKS];
  logic [PB_IDX_WIDTH-1:0] r_next [MAX_NO_OF_PROGRAM_BLOCKS];
  logic                    r_last [MAX_NO_OF_PROGRAM_BLOCKS];

  state_e                            r_state, w_state_d;
  logic [PB_IDX_WIDTH-1:0]           r_cur, w_cur_d;
  logic [CNT_WIDTH-1:0]              r_cnt, w_cnt_d;
  logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0] r_s, w_onehot;
  logic                              r_done, w_done_d;
  logic                              r_err, w_err_d;
  logic                              w_cfg_addr_ok, w_cfg_ok;
  logic [PB_IDX_WIDTH-1:0]           w_succ;

  function automatic logic [CNT_WIDTH-1:0] f_load(input logic [CNT_WIDTH-1:0] len);
    return (len == '0) ? CNT_WIDTH'(1) : len;
  endfunction

  assign w_cfg_addr_ok = ({1'b0, i_cfg_addr} < MaxPb);
  assign w_cfg_ok      = i_cfg_we && (r_state != StRun) && w_cfg_addr_ok;
  assign w_succ        = r_next[r_cur];

  always_ff @(posedge i_clk) begin
    if (w_cfg_ok) begin
      r_len[i_cfg_addr]  <= i_cfg_len;
      r_next[i_cfg_addr] <= i_cfg_next;
      r_last[i_cfg_addr] <= i_cfg_last;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cur_d   = r_cur;
    w_cnt_d   = r_cnt;
    w_done_d  = 1'b0;
    w_err_d   = r_err;
    if (i_abort) begin
      w_state_d = StIdle;
    end else if (i_start && (r_state != StRun)) begin
      w_state_d = StRun;
      w_cur_d   = '0;
      w_cnt_d   = f_load(r_len[0]);
      w_err_d   = 1'b0;
    end else if (i_step && (r_state == StRun)) begin
      if (r_cnt != CNT_WIDTH'(1)) begin
        w_cnt_d = r_cnt - CNT_WIDTH'(1);
      end else if (r_last[r_cur]) begin
        w_state_d = StDone;
        w_done_d  = 1'b1;
      end else if ({1'b0, w_succ} >= MaxPb) begin
        w_state_d = StDone;
        w_err_d   = 1'b1;
      end else begin
        w_cur_d = w_succ;
        w_cnt_d = f_load(r_len[w_succ]);
      end
    end
    // A rejected config write flags an error even if a start clears it this cycle.
    if (i_cfg_we && ((r_state == StRun) || !w_cfg_addr_ok)) w_err_d = 1'b1;
  end

  pb_bin2onehot #(
    .N(MAX_NO_OF_PROGRAM_BLOCKS),
    .W(PB_IDX_WIDTH)
  ) u_bin2onehot (
    .i_idx   (w_cur_d),
    .o_onehot(w_onehot)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cur   <= '0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cur   <= w_cur_d;
      r_cnt   <= w_cnt_d;
      r_s     <= (w_state_d == StRun) ? w_onehot : '0;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
    end
  end

  assign o_s      = r_s;
  assign o_pb_idx = r_cur;
  assign o_busy   = (r_state == StRun);
  assign o_done   = r_done;
  assign o_err    = r_err;

endmodule

// File: tb/tb_pb_onehot_sequencer.sv
// Self-checking bench: directed scenarios plus random chains checked against a table-walk model.
module tb_pb_onehot_sequencer;

  localparam int unsigned NPB = 12;
  localparam int unsigned CW  = 16;
  localparam int unsigned IW  = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0, i_cfg_we = 1'b0, i_cfg_last = 1'b0;
  logic [IW-1:0] i_cfg_addr = '0, i_cfg_next = '0;
  logic [CW-1:0] i_cfg_len = '0;
  logic          i_start = 1'b0, i_step = 1'b0, i_abort = 1'b0;
  logic [NPB-1:0] o_s;
  logic [IW-1:0]  o_pb_idx;
  logic           o_busy, o_done, o_err;

  int n_checks = 0;
  int n_pass   = 0;

  int m_len  [NPB];
  int m_next [NPB];
  bit m_last [NPB];
  int exp_trace[$];
  int exp_outcome;  // 0 = still running at bound, 1 = done, 2 = bad successor

  always #5 clk = ~clk;

  pb_onehot_sequencer #(
    .MAX_NO_OF_PROGRAM_BLOCKS(NPB),
    .CNT_WIDTH(CW),
    .PB_IDX_WIDTH(IW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
    .i_cfg_len(i_cfg_len), .i_cfg_next(i_cfg_next), .i_cfg_last(i_cfg_last),
    .i_start(i_start), .i_step(i_step), .i_abort(i_abort),
    .o_s(o_s), .o_pb_idx(o_pb_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  function automatic logic [NPB-1:0] onehot(input int i);
    logic [NPB-1:0] v;
    v = '0;
    if (i >= 0 && i < NPB) v[i] = 1'b1;
    return v;
  endfunction

  // Expand the table into the sequence of selected blocks, one entry per iteration.
  function automatic void walk();
    int cur, reps;
    exp_trace.delete();
    cur = 0;
    forever begin
      reps = (m_len[cur] == 0) ? 1 : m_len[cur];
      repeat (reps) exp_trace.push_back(cur);
      if (m_last[cur]) begin exp_outcome = 1; return; end
      if (m_next[cur] >= NPB) begin exp_outcome = 2; return; end
      if (exp_trace.size() >= 40) begin exp_outcome = 0; return; end
      cur = m_next[cur];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    i_rst = 1'b0; i_cfg_we = 1'b0; i_start = 1'b0; i_step = 1'b0; i_abort = 1'b0;
  endtask

  task automatic cfg_write(input int a, input int len, input int nxt, input bit last);
    i_cfg_we = 1'b1; i_cfg_addr = a[IW-1:0]; i_cfg_len = len[CW-1:0];
    i_cfg_next = nxt[IW-1:0]; i_cfg_last = last;
    tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    n_checks++;
    if ({o_s, o_busy, o_done, o_err, o_pb_idx} !== {onehot(-1), 3'b000, 4'd0})
      $display("FAIL reset_values: got s=%h busy=%b done=%b err=%b idx=%0d want all zero",
               o_s, o_busy, o_done, o_err, o_pb_idx);
    else n_pass++;
    cfg_write(0, 1, 2, 0);
    cfg_write(2, 5, 0, 1);
    i_start = 1'b1; tick();
    i_step = 1'b1; tick();
    cfg_write(5, 1, 0, 0);
    n_checks++;
    if ({o_s, o_busy, o_err} !== {12'h004, 2'b11})
      $display("FAIL reset_pre_run: got s=%h busy=%b err=%b want 004 1 1", o_s, o_busy, o_err);
    else n_pass++;
    i_rst = 1'b1; i_step = 1'b1;
    tick();
    n_checks++;
    if ({o_s, o_busy, o_done, o_err} !== {onehot(-1), 3'b000})
      $display("FAIL reset_mid_run: got s=%h busy=%b done=%b err=%b want 0", o_s, o_busy, o_done,
               o_err);
    else n_pass++;
    i_step = 1'b1; tick();
    n_checks++;
    if ({o_s, o_busy} !== {onehot(-1), 1'b0})
      $display("FAIL step_in_idle: got s=%h busy=%b want 0 0", o_s, o_busy);
    else n_pass++;
  endtask

  task automatic test_chain();
    logic [NPB-1:0] exp_s [6];
    exp_s = '{12'h001, 12'h001, 12'h008, 12'h080, 12'h080, 12'h080};
    cfg_write(0, 2, 3, 0);
    cfg_write(3, 1, 7, 0);
    cfg_write(7, 3, 0, 1);
    i_start = 1'b1; tick();
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if ({o_s, o_busy, o_done} !== {exp_s[k], 2'b10})
        $display("FAIL chain_s%0d: got s=%h busy=%b done=%b want %h 1 0", k, o_s, o_busy, o_done,
                 exp_s[k]);
      else n_pass++;
      if (k == 3) begin
        i_start = 1'b1; tick();
        n_checks++;
        if (o_s !== 12'h080) $display("FAIL start_in_run: got s=%h want 080", o_s);
        else n_pass++;
      end
      i_step = 1'b1; tick();
    end
    n_checks++;
    if ({o_s, o_busy, o_done, o_err} !== {onehot(-1), 3'b010})
      $display("FAIL chain_done: got s=%h busy=%b done=%b err=%b want 0 0 1 0", o_s, o_busy,
               o_done, o_err);
    else n_pass++;
    tick();
    n_checks++;
    if (o_done !== 1'b0) $display("FAIL chain_done_pulse: got done=%b want 0", o_done);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    cfg_write(0, 0, 0, 1);
    i_start = 1'b1; tick();
    repeat (3) begin
      n_checks++;
      if ({o_s, o_busy} !== {12'h001, 1'b1})
        $display("FAIL zero_len_hold: got s=%h busy=%b want 001 1", o_s, o_busy);
      else n_pass++;
      tick();
    end
    i_step = 1'b1; tick();
    n_checks++;
    if ({o_s, o_busy, o_done} !== {onehot(-1), 2'b01})
      $display("FAIL zero_len_done: got s=%h busy=%b done=%b want 0 0 1", o_s, o_busy, o_done);
    else n_pass++;
  endtask

  task automatic test_bad_next();
    cfg_write(0, 1, 2, 0);
    cfg_write(2, 1, 13, 0);
    i_start = 1'b1; tick();
    i_step = 1'b1; tick();
    n_checks++;
    if ({o_s, o_pb_idx} !== {12'h004, 4'd2})
      $display("FAIL bad_next_reach: got s=%h idx=%0d want 004 2", o_s, o_pb_idx);
    else n_pass++;
    i_step = 1'b1; tick();
    n_checks++;
    if ({o_s, o_busy, o_done, o_err} !== {onehot(-1), 3'b001})
      $display("FAIL bad_next_err: got s=%h busy=%b done=%b err=%b want 0 0 0 1", o_s, o_busy,
               o_done, o_err);
    else n_pass++;
    i_start = 1'b1; tick();
    n_checks++;
    if ({o_s, o_busy, o_err} !== {12'h001, 2'b10})
      $display("FAIL start_clears_err: got s=%h busy=%b err=%b want 001 1 0", o_s, o_busy, o_err);
    else n_pass++;
    i_abort = 1'b1; tick();
  endtask

  task automatic test_cfg_busy();
    cfg_write(0, 2, 0, 1);
    i_start = 1'b1; tick();
    cfg_write(0, 1, 0, 1);
    n_checks++;
    if ({o_s, o_busy, o_err} !== {12'h001, 2'b11})
      $display("FAIL cfg_busy_err: got s=%h busy=%b err=%b want 001 1 1", o_s, o_busy, o_err);
    else n_pass++;
    for (int run = 0; run < 2; run++) begin
      if (run == 1) begin
        i_start = 1'b1; tick();
      end
      i_step = 1'b1; tick();
      n_checks++;
      if ({o_s, o_busy, o_done} !== {12'h001, 2'b10})
        $display("FAIL cfg_busy_len_r%0d: got s=%h busy=%b done=%b want 001 1 0", run, o_s,
                 o_busy, o_done);
      else n_pass++;
      i_step = 1'b1; tick();
      n_checks++;
      if ({o_s, o_busy, o_done, o_err} !== {onehot(-1), 2'b01, (run == 0)})
        $display("FAIL cfg_busy_done_r%0d: got s=%h busy=%b done=%b err=%b", run, o_s, o_busy,
                 o_done, o_err);
      else n_pass++;
    end
    cfg_write(12, 1, 0, 1);
    n_checks++;
    if ({o_busy, o_err} !== 2'b01)
      $display("FAIL cfg_bad_addr: got busy=%b err=%b want 0 1", o_busy, o_err);
    else n_pass++;
  endtask

  task automatic test_abort();
    i_start = 1'b1; i_abort = 1'b1; tick();
    n_checks++;
    if ({o_s, o_busy, o_done, o_err} !== {onehot(-1), 3'b001})
      $display("FAIL start_abort_idle: got s=%h busy=%b done=%b err=%b want 0 0 0 1", o_s,
               o_busy, o_done, o_err);
    else n_pass++;
    cfg_write(0, 3, 0, 1);
    i_start = 1'b1; tick();
    i_step = 1'b1; i_abort = 1'b1; tick();
    n_checks++;
    if ({o_s, o_busy, o_done, o_err} !== {onehot(-1), 3'b000})
      $display("FAIL step_abort_run: got s=%h busy=%b done=%b err=%b want 0 0 0 0", o_s, o_busy,
               o_done, o_err);
    else n_pass++;
    tick();
    n_checks++;
    if ({o_s, o_busy, o_done} !== {onehot(-1), 2'b00})
      $display("FAIL abort_stays_idle: got s=%h busy=%b done=%b want 0 0 0", o_s, o_busy, o_done);
    else n_pass++;
  endtask

  task automatic test_random_chains();
    int nsteps, gap;
    for (int it = 0; it < 25; it++) begin
      for (int a = 0; a < NPB; a++) begin
        m_len[a]  = $urandom_range(0, 3);
        m_next[a] = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11);
        m_last[a] = ($urandom_range(0, 3) == 0);
        cfg_write(a, m_len[a], m_next[a], m_last[a]);
      end
      walk();
      i_start = 1'b1; tick();
      n_checks++;
      if ({o_s, o_busy, o_done, o_err, o_pb_idx} !== {onehot(0), 3'b100, 4'd0})
        $display("FAIL rnd%0d_start: got s=%h busy=%b done=%b err=%b idx=%0d", it, o_s, o_busy,
                 o_done, o_err, o_pb_idx);
      else n_pass++;
      nsteps = (exp_outcome == 0) ? exp_trace.size() - 1 : exp_trace.size();
      for (int k = 0; k < nsteps; k++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          tick();
          n_checks++;
          if ({o_s, o_busy} !== {onehot(exp_trace[k]), 1'b1})
            $display("FAIL rnd%0d_hold%0d: got s=%h want %h", it, k, o_s, onehot(exp_trace[k]));
          else n_pass++;
        end
        i_step = 1'b1; tick();
        if (k < exp_trace.size() - 1) begin
          n_checks++;
          if ({o_s, o_busy, o_done, o_err, o_pb_idx} !==
              {onehot(exp_trace[k+1]), 3'b100, IW'(exp_trace[k+1])})
            $display("FAIL rnd%0d_step%0d: got s=%h idx=%0d busy=%b want s=%h idx=%0d", it, k,
                     o_s, o_pb_idx, o_busy, onehot(exp_trace[k+1]), exp_trace[k+1]);
          else n_pass++;
        end else begin
          n_checks++;
          if ({o_s, o_busy, o_done, o_err} !== {onehot(-1), 1'b0, exp_outcome == 1,
                                                 exp_outcome == 2})
            $display("FAIL rnd%0d_end: got s=%h busy=%b done=%b err=%b outcome=%0d", it, o_s,
                     o_busy, o_done, o_err, exp_outcome);
          else n_pass++;
        end
      end
      if (exp_outcome == 0) i_abort = 1'b1;
      tick();
      n_checks++;
      if ({o_s, o_busy, o_done} !== {onehot(-1), 2'b00})
        $display("FAIL rnd%0d_idle: got s=%h busy=%b done=%b want 0 0 0", it, o_s, o_busy,
                 o_done);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_chain();
    test_zero_len();
    test_bad_next();
    test_cfg_busy();
    test_abort();
    test_random_chains();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
